// File: rtl/cordic_sched.sv
// cordic_sched: two-requester round-robin front end for a fixed-latency
// cosine pipeline. It accepts one operand per cycle, drives it into the
// pipeline, and routes each result back to the requester that issued it,
// in acceptance order.
// Optional build macro CORDIC_SCHED_PERF_EN adds the saturating
// issue_cnt / conflict_cnt performance counters.
module cordic_sched #(
    parameter int W   = 32,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_data,
    output logic [W-1:0] dp_operand,
    input  logic [W-1:0] dp_result,
    output logic         busy,
    output logic [4:0]   inflight
`ifdef CORDIC_SCHED_PERF_EN
    ,
    output logic [15:0]  issue_cnt,
    output logic [15:0]  conflict_cnt
`endif
);

    // At LAT=31 up to 32 operations can be outstanding, one more than the
    // 5-bit port can show, so the internal count is 6 bits and the port
    // saturates.
    function automatic logic [4:0] sat_inflight(input logic [5:0] v);
        return v[5] ? 5'h1f : v[4:0];
    endfunction

    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           last_gnt;     // requester id of the most recent grant
    logic [LAT-1:0] tag_vld_sr;
    logic [LAT-1:0] tag_id_sr;
    logic           ret_vld_p1;   // result for this tag appears on dp_result now
    logic           ret_id_p1;
    logic [5:0]     cnt;

    // Round-robin arbitration: sole valid wins, on a tie the requester not
    // granted last wins; nothing is granted while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_gnt)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Pointer update and operand register, both only on an accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt   <= 1'b1;
            dp_operand <= '0;
        end else if (accept) begin
            last_gnt   <= grant1;
            dp_operand <= grant1 ? req1_data : req0_data;
        end
    end

    // Tag shift register: one slot per pipeline cycle, then a retire stage
    // that lines up with the cycle dp_result carries the matching result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_sr <= '0;
            tag_id_sr  <= '0;
            ret_vld_p1 <= 1'b0;
            ret_id_p1  <= 1'b0;
        end else begin
            tag_vld_sr[0] <= accept;
            tag_id_sr[0]  <= grant1;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_sr[i] <= tag_vld_sr[i-1];
                tag_id_sr[i]  <= tag_id_sr[i-1];
            end
            ret_vld_p1 <= tag_vld_sr[LAT-1];
            ret_id_p1  <= tag_id_sr[LAT-1];
        end
    end

    // Response capture: only the addressed port's data moves; strobes last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= ret_vld_p1 && !ret_id_p1;
            rsp1_valid <= ret_vld_p1 && ret_id_p1;
            if (ret_vld_p1 && !ret_id_p1) begin
                rsp0_data <= dp_result;
            end
            if (ret_vld_p1 && ret_id_p1) begin
                rsp1_data <= dp_result;
            end
        end
    end

    // Outstanding-operation count: +1 per accept, -1 per returned strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 6'(accept) - 6'(ret_vld_p1);
        end
    end

    assign inflight = sat_inflight(cnt);
    assign busy     = (cnt != 6'd0);

`ifdef CORDIC_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    // Performance counters: acceptances and both-valid cycles, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (accept) begin
                issue_cnt <= sat_inc16(issue_cnt);
            end
            if (req0_valid && req1_valid) begin
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
        end
    end
`endif

endmodule
